// File: rtl/secret_pin_if.sv
// secret_pin_if: request/seed inputs and PIN/status outputs of the secret PIN generator
interface secret_pin_if;
    logic        req;
    logic        seed_load;
    logic [15:0] seed_in;
    logic [3:0]  pin0;
    logic [3:0]  pin1;
    logic [3:0]  pin2;
    logic [3:0]  pin3;
    logic        pin_valid;
    logic        busy;
    modport master (output req, seed_load, seed_in, input pin0, pin1, pin2, pin3, pin_valid, busy);
    modport slave  (input req, seed_load, seed_in, output pin0, pin1, pin2, pin3, pin_valid, busy);
endinterface

// File: rtl/secret_pin_generator.sv
// secret_pin_generator: draws a 4-digit PIN from a free-running LFSR by bounded rejection sampling
module secret_pin_generator #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input logic         clock,
    input logic         reset,
    secret_pin_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRAW, VALID} state_t;
    localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;
    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  rej_q, rej_d;
    logic [3:0]  pin_q [4];
    logic [3:0]  pin_d [4];
    logic        busy_q, busy_d;
    logic        pin_valid_q, pin_valid_d;
    logic [3:0]  cand;
    logic        accept;
    always_comb begin
        cand        = lfsr_q[3:0];
        // an eighth consecutive reject is folded into 0-5 so a draw never exceeds 32 cycles
        accept      = (cand < 4'd10) || (rej_q == 3'd7);
        lfsr_d      = bus.seed_load ? ((bus.seed_in == 16'h0000) ? 16'h0001 : bus.seed_in)
                                    : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        state_d     = state_q;
        idx_d       = idx_q;
        rej_d       = rej_q;
        pin_d       = pin_q;
        case (state_q)
            IDLE, VALID: begin
                if (bus.req) begin
                    state_d = DRAW;
                    idx_d   = 2'd0;
                    rej_d   = 3'd0;
                end
            end
            DRAW: begin
                if (accept) begin
                    pin_d[idx_q] = (cand < 4'd10) ? cand : cand - 4'd10;
                    rej_d        = 3'd0;
                    idx_d        = idx_q + 2'd1;
                    state_d      = (idx_q == 2'd3) ? VALID : DRAW;
                end else begin
                    rej_d = rej_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d == DRAW);
        pin_valid_d = (state_d == VALID);
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED_NZ;
            idx_q       <= 2'd0;
            rej_q       <= 3'd0;
            pin_q       <= '{default: 4'd0};
            busy_q      <= 1'b0;
            pin_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            idx_q       <= idx_d;
            rej_q       <= rej_d;
            pin_q       <= pin_d;
            busy_q      <= busy_d;
            pin_valid_q <= pin_valid_d;
        end
    end
    assign bus.pin0      = pin_q[0];
    assign bus.pin1      = pin_q[1];
    assign bus.pin2      = pin_q[2];
    assign bus.pin3      = pin_q[3];
    assign bus.busy      = busy_q;
    assign bus.pin_valid = pin_valid_q;
endmodule

// File: tb/tb_secret_pin_generator.sv
// tb_secret_pin_generator: directed and seeded-random draws checked by a queue scoreboard
module tb_secret_pin_generator;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   folds = 0;
    secret_pin_if bus ();
    secret_pin_generator #(.SEED(16'hACE1)) dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    typedef struct {
        logic [15:0] pins;
        int          lat;
        int          issue;
    } exp_t;
    exp_t sb[$];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction
    function automatic void model(input logic [15:0] seed, output logic [15:0] pins, output int lat, output int nfold);
        logic [15:0] s;
        logic [3:0]  c;
        int          idx;
        int          rej;
        s = (seed == 16'h0000) ? 16'h0001 : seed;
        pins = '0; lat = 0; nfold = 0; idx = 0; rej = 0;
        while (idx < 4) begin
            c = s[3:0];
            lat++;
            if (c < 4'd10) begin
                pins[idx*4 +: 4] = c; rej = 0; idx++;
            end else if (rej == 7) begin
                pins[idx*4 +: 4] = c - 4'd10; nfold++; rej = 0; idx++;
            end else begin
                rej++;
            end
            s = step(s);
        end
    endfunction
    logic prev_valid = 1'b0;
    int   busy_cnt = 0;
    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
            busy_cnt = 0;
        end else begin
            if (bus.busy && bus.pin_valid) check("busy_valid_exclusive", 1, 0);
            if (bus.busy) busy_cnt++;
            if (bus.pin_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    int   lat;
                    e = sb.pop_front();
                    lat = cyc - e.issue;
                    check("pins", {bus.pin3, bus.pin2, bus.pin1, bus.pin0}, e.pins);
                    check("latency", lat, e.lat);
                    check("busy_cycles", busy_cnt, lat);
                    check("latency_range", (lat >= 4 && lat <= 32), 1);
                    check("digit_range", (bus.pin0 <= 9 && bus.pin1 <= 9 && bus.pin2 <= 9 && bus.pin3 <= 9), 1);
                end
                busy_cnt = 0;
            end
            prev_valid = bus.pin_valid;
        end
    end
    task automatic draw(input logic [15:0] seed, input logic [15:0] ep, input int el, input bit extra);
        bit done;
        done = 1'b0;
        @(negedge clock);
        bus.req = 1'b1; bus.seed_load = 1'b1; bus.seed_in = seed;
        sb.push_back('{ep, el, cyc + 1});
        @(negedge clock);
        bus.req = 1'b0; bus.seed_load = 1'b0;
        check("valid_drops_on_req", bus.pin_valid, 0);
        check("busy_after_req", bus.busy, 1);
        for (int i = 0; i < 40 && !done; i++) begin
            bus.req = extra && (i == 1 || i == 2);
            @(negedge clock);
            done = bus.pin_valid;
        end
        bus.req = 1'b0;
        if (!done) check("valid_timeout", 0, 1);
    endtask
    initial begin
        logic [15:0] p;
        int          l;
        int          f;
        bus.req = 1'b0; bus.seed_load = 1'b0; bus.seed_in = 16'h0000;
        repeat (3) @(negedge clock);
        check("rst_pins", {bus.pin3, bus.pin2, bus.pin1, bus.pin0}, 0);
        check("rst_valid", bus.pin_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_lfsr", dut.lfsr_q, 16'hACE1);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clock);
            check("idle_quiet", {bus.busy, bus.pin_valid}, 0);
        end
        draw(16'h0001, 16'h8421, 4, 1'b0);
        draw(16'h000F, 16'h0008, 7, 1'b0);
        draw(16'h0000, 16'h8421, 4, 1'b0);
        draw(16'h000F, 16'h0008, 7, 1'b1);
        repeat (5) @(negedge clock);
        check("hold_valid", bus.pin_valid, 1);
        check("hold_busy", bus.busy, 0);
        check("hold_pins", {bus.pin3, bus.pin2, bus.pin1, bus.pin0}, 16'h0008);
        draw(16'h0001, 16'h8421, 4, 1'b0);
        model(16'h583F, p, l, f);
        folds += f;
        draw(16'h583F, p, l, 1'b0);
        check("fold_pin0", bus.pin0, 5);
        @(negedge clock);
        bus.req = 1'b1; bus.seed_load = 1'b1; bus.seed_in = 16'h000F;
        @(negedge clock);
        bus.req = 1'b0; bus.seed_load = 1'b0;
        @(negedge clock);
        check("mid_draw_busy", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_pins", {bus.pin3, bus.pin2, bus.pin1, bus.pin0}, 0);
        check("async_rst_valid", bus.pin_valid, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_lfsr", dut.lfsr_q, 16'hACE1);
        sb.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check("post_rst_idle", {bus.busy, bus.pin_valid}, 0);
        end
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] s;
            s = 16'($urandom_range(0, 65535));
            model(s, p, l, f);
            folds += f;
            draw(s, p, l, 1'b0);
        end
        repeat (2) @(negedge clock);
        check("fold_exercised", (folds > 0), 1);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
